// File: rtl/psram_word_arbiter.sv
// psram_word_arbiter: round-robin share of a 16-bit psram between
// the rv32i ifetch and data ports, one word as up to two halfwords.
module psram_word_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [21:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [21:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        ps_bank_sel,
   output logic [21:0] ps_addr,
   output logic        ps_write_en,
   output logic        ps_read_en,
   output logic [15:0] ps_data_in,
   output logic        ps_write_high_byte,
   output logic        ps_write_low_byte,
   input  logic        ps_read_avail,
   input  logic [15:0] ps_data_out,
   input  logic        ps_busy
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      SETTLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic        gnt_d;
   logic        we_r;
   logic        half_r;
   logic [21:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;
   logic [15:0] lo_r;

   logic        take_d;
   logic        need_hi;
   logic        no_op;
   logic        issue;

   // d wins a tie unless it was the last port served
   assign take_d  = d_req & (~i_req | ~gnt_d);
   assign need_hi = ~we_r | (|wstrb_r[3:2]);
   assign no_op   = we_r & ~(|wstrb_r);

   assign ps_bank_sel        = addr_r[21];
   assign ps_addr            = {addr_r[20:0], half_r};
   assign ps_data_in         = half_r ? wdata_r[31:16] : wdata_r[15:0];
   assign ps_write_low_byte  = we_r & (half_r ? wstrb_r[2] : wstrb_r[0]);
   assign ps_write_high_byte = we_r & (half_r ? wstrb_r[3] : wstrb_r[1]);
   assign ps_read_en         = issue & ~we_r;
   assign ps_write_en        = issue & we_r;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next state, issue strobe and acks
   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      i_ack    = 1'b0;
      d_ack    = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_req || d_req) state_nx = ISSUE;
         end
         ISSUE: begin
            if (no_op) begin
               state_nx = RESP;
            end else if (!ps_busy) begin
               issue    = 1'b1;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            state_nx = WAIT;
         end
         WAIT: begin
            if (!ps_busy)
               state_nx = (!half_r && need_hi) ? ISSUE : RESP;
         end
         RESP: begin
            i_ack    = ~gnt_d;
            d_ack    = gnt_d;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // grant latch, half sequencing and read data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_d   <= 1'b0;
         we_r    <= 1'b0;
         half_r  <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
         wstrb_r <= '0;
         lo_r    <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         if (state == IDLE && (i_req || d_req)) begin
            gnt_d <= take_d;
            if (take_d) begin
               addr_r  <= d_addr;
               we_r    <= d_we;
               wdata_r <= d_wdata;
               wstrb_r <= d_wstrb;
               half_r  <= d_we & ~(|d_wstrb[1:0]);
            end else begin
               addr_r  <= i_addr;
               we_r    <= 1'b0;
               wdata_r <= '0;
               wstrb_r <= '0;
               half_r  <= 1'b0;
            end
         end
         if (state == WAIT && !ps_busy) begin
            if (!we_r) begin
               assert (ps_read_avail);
               if (!half_r)    lo_r    <= ps_data_out;
               else if (gnt_d) d_rdata <= {ps_data_out, lo_r};
               else            i_rdata <= {ps_data_out, lo_r};
            end
            if (!half_r && need_hi) half_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_psram_word_arbiter.sv
// tb_psram_word_arbiter: directed and random checks of the arbiter
// against a byte-level memory reference and a timed psram model.
module tb_psram_word_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [21:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [21:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        ps_bank_sel;
   logic [21:0] ps_addr;
   logic        ps_write_en;
   logic        ps_read_en;
   logic [15:0] ps_data_in;
   logic        ps_write_high_byte;
   logic        ps_write_low_byte;
   logic        ps_read_avail = 1'b0;
   logic [15:0] ps_data_out = '0;
   logic        ps_busy = 1'b0;

   psram_word_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_ack(d_ack), .d_rdata(d_rdata),
      .ps_bank_sel(ps_bank_sel), .ps_addr(ps_addr),
      .ps_write_en(ps_write_en), .ps_read_en(ps_read_en),
      .ps_data_in(ps_data_in),
      .ps_write_high_byte(ps_write_high_byte),
      .ps_write_low_byte(ps_write_low_byte),
      .ps_read_avail(ps_read_avail), .ps_data_out(ps_data_out),
      .ps_busy(ps_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // initial content of any halfword never written
   function automatic logic [15:0] dflt(input logic [22:0] hk);
      logic [31:0] v;
      v = ({9'd0, hk} * 32'd40503) ^ 32'h5AC3;
      return v[15:0];
   endfunction

   // ---------------- psram model (halfword storage, timed) -----------
   logic [15:0] mm [logic [22:0]];
   int          lat = 4;
   int          hold = 0;
   int          cnt = 0;
   logic        m_rd = 1'b0;
   logic [22:0] m_key = '0;

   function automatic logic [15:0] mrd(input logic [22:0] k);
      if (mm.exists(k)) return mm[k];
      return dflt(k);
   endfunction

   always @(posedge clk) begin
      logic [22:0] k;
      logic [15:0] cur;
      ps_read_avail <= 1'b0;
      if (cnt == 1) begin
         ps_read_avail <= m_rd;
         if (m_rd) ps_data_out <= mrd(m_key);
      end
      ps_busy <= (cnt > 1) || (hold > 0);
      if (cnt > 0) cnt--;
      if (hold > 0) hold--;
      if (ps_read_en || ps_write_en) begin
         k = {ps_bank_sel, ps_addr};
         m_key = k;
         m_rd = ps_read_en;
         cnt = lat;
         if (ps_write_en) begin
            cur = mrd(k);
            if (ps_write_low_byte)  cur[7:0]  = ps_data_in[7:0];
            if (ps_write_high_byte) cur[15:8] = ps_data_in[15:8];
            mm[k] = cur;
         end
      end
   end

   // ---------------- reference: byte-addressed word memory -----------
   logic [7:0] rb [logic [23:0]];

   function automatic logic [7:0] rbyte(input logic [21:0] a,
                                        input logic [1:0] n);
      logic [15:0] h;
      if (rb.exists({a, n})) return rb[{a, n}];
      h = dflt({a, n[1]});
      return n[0] ? h[15:8] : h[7:0];
   endfunction

   function automatic logic [31:0] ref_word(input logic [21:0] a);
      return {rbyte(a, 2'd3), rbyte(a, 2'd2), rbyte(a, 2'd1), rbyte(a, 2'd0)};
   endfunction

   task automatic ref_write(input logic [21:0] a, input logic [31:0] w,
                            input logic [3:0] s);
      for (int n = 0; n < 4; n++)
         if (s[n]) rb[{a, 2'(n)}] = w[8*n +: 8];
   endtask

   task automatic preload(input logic [21:0] a, input logic [31:0] w);
      mm[{a, 1'b0}] = w[15:0];
      mm[{a, 1'b1}] = w[31:16];
      ref_write(a, w, 4'hF);
   endtask

   // ---------------- monitors ---------------------------------------
   int n_rd = 0;
   int n_wr = 0;
   int n_iack = 0;
   int n_dack = 0;
   logic [21:0] rd_addrs[$];
   logic [40:0] wr_last = '0;

   always @(negedge clk) begin
      if (ps_read_en || ps_write_en) begin
         checks++;
         assert (!(ps_read_en && ps_write_en) && !ps_busy && cnt == 0)
         else begin
            errors++;
            $error("FAIL psram_issue obs=rd%b wr%b busy%b cnt%0d exp=single idle op",
                   ps_read_en, ps_write_en, ps_busy, cnt);
         end
         if (ps_read_en) begin
            n_rd++;
            rd_addrs.push_back(ps_addr);
         end
         if (ps_write_en) begin
            n_wr++;
            wr_last = {ps_bank_sel, ps_addr, ps_data_in,
                       ps_write_high_byte, ps_write_low_byte};
         end
      end
      if (i_ack) n_iack++;
      if (d_ack) n_dack++;
      if (i_ack || d_ack) begin
         checks++;
         assert (!(i_ack && d_ack)) else begin
            errors++;
            $error("FAIL dual_ack obs=11 exp=one");
         end
      end
   end

   logic [108:0] outs;
   assign outs = {i_ack, i_rdata, d_ack, d_rdata, ps_bank_sel, ps_addr,
                  ps_write_en, ps_read_en, ps_data_in,
                  ps_write_high_byte, ps_write_low_byte};

   // ---------------- stimulus helpers -------------------------------
   function automatic logic [21:0] rnd_addr();
      return {1'($urandom_range(1)), 17'd0, 4'($urandom_range(15))};
   endfunction

   task automatic wait_ack(input logic isd, output int at);
      int t;
      t = 0;
      at = -1;
      while (at < 0 && t < 1000) begin
         @(negedge clk);
         t++;
         if (isd ? d_ack : i_ack) at = cyc;
      end
      chk("ack_seen", (at >= 0), 1'b1);
   endtask

   task automatic i_read(input logic [21:0] a, input string tag);
      int at;
      i_addr = a;
      i_req = 1'b1;
      wait_ack(1'b0, at);
      i_req = 1'b0;
      i_addr = 22'($urandom);
      chk(tag, i_rdata, ref_word(a));
   endtask

   task automatic d_op(input logic we, input logic [21:0] a,
                       input logic [31:0] w, input logic [3:0] s,
                       input string tag);
      int at;
      d_we = we;
      d_addr = a;
      d_wdata = w;
      d_wstrb = s;
      d_req = 1'b1;
      wait_ack(1'b1, at);
      d_req = 1'b0;
      d_wdata = $urandom;
      if (we) ref_write(a, w, s);
      else chk(tag, d_rdata, ref_word(a));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_both(input int n);
      logic exp_d;
      int got;
      int t;
      logic [21:0] ia;
      logic [21:0] da;
      exp_d = 1'b1;
      got = 0;
      t = 0;
      ia = rnd_addr();
      da = rnd_addr();
      i_addr = ia;
      d_addr = da;
      d_we = 1'b0;
      d_wstrb = 4'hF;
      i_req = 1'b1;
      d_req = 1'b1;
      while (got < n && t < 4000) begin
         @(negedge clk);
         t++;
         if (i_ack || d_ack) begin
            chk("rr_order", d_ack, exp_d);
            if (d_ack) begin
               chk("rr_d_rdata", d_rdata, ref_word(da));
               da = rnd_addr();
               d_addr = da;
            end else begin
               chk("rr_i_rdata", i_rdata, ref_word(ia));
               ia = rnd_addr();
               i_addr = ia;
            end
            exp_d = ~exp_d;
            got++;
         end
      end
      chk("rr_count", got, n);
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   // ---------------- directed + random sequence ---------------------
   initial begin
      int b_rd;
      int b_wr;
      int b_ack;
      int c0;
      int c1;
      int at;
      int t;
      logic [21:0] a;
      logic [31:0] w;
      logic [3:0] s;
      logic we;

      reset = 1'b1;
      i_req = 1'b0;
      i_addr = '0;
      d_req = 1'b0;
      d_we = 1'b0;
      d_addr = '0;
      d_wdata = '0;
      d_wstrb = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs, 109'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_outs", outs, 109'd0);

      // two-half ifetch read
      preload(22'h000010, 32'hDEADBEEF);
      lat = 10;
      rd_addrs.delete();
      b_ack = n_iack;
      i_read(22'h000010, "ifetch_word");
      repeat (2) @(negedge clk);
      chk("ifetch_nrd", rd_addrs.size(), 2);
      if (rd_addrs.size() == 2) begin
         chk("ifetch_h0_addr", rd_addrs[0], 22'h000020);
         chk("ifetch_h1_addr", rd_addrs[1], 22'h000021);
      end
      chk("ifetch_acks", n_iack - b_ack, 1);
      chk("ifetch_rdata", i_rdata, 32'hDEADBEEF);

      // upper-half-only write
      b_wr = n_wr;
      d_op(1'b1, 22'h200003, 32'h11223344, 4'hC, "wr_hi");
      chk("wr_hi_count", n_wr - b_wr, 1);
      chk("wr_hi_fields", wr_last, {1'b1, 22'h000007, 16'h1122, 1'b1, 1'b1});
      d_op(1'b0, 22'h200003, 32'h0, 4'h0, "wr_hi_readback");

      // empty write: no psram access, ack two cycles after request
      @(negedge clk);
      b_wr = n_wr;
      d_we = 1'b1;
      d_addr = 22'h000005;
      d_wstrb = 4'h0;
      d_req = 1'b1;
      c0 = cyc;
      wait_ack(1'b1, at);
      d_req = 1'b0;
      chk("wr0_latency", at - c0, 2);
      chk("wr0_no_write", n_wr - b_wr, 0);

      // simultaneous requests, d first, then sustained alternation
      lat = 3;
      do_reset();
      run_both(2);
      do_reset();
      run_both(8);

      // reset during the h1 WAIT of a read
      lat = 10;
      @(negedge clk);
      b_ack = n_iack;
      i_addr = 22'h000009;
      i_req = 1'b1;
      t = 0;
      while (!(ps_read_en && ps_addr[0]) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("h1_issue_seen", (t < 500), 1'b1);
      repeat (2) @(negedge clk);
      chk("h1_wait_busy", ps_busy, 1'b1);
      reset = 1'b1;
      i_req = 1'b0;
      @(negedge clk);
      chk("midreset_outs", outs, 109'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midreset_no_ack", n_iack - b_ack, 0);
      b_rd = n_rd;
      i_read(22'h20000A, "post_reset_read");
      chk("post_reset_nrd", n_rd - b_rd, 2);

      // psram busy on entry to ISSUE for five cycles
      lat = 3;
      @(negedge clk);
      b_rd = n_rd;
      hold = 5;
      i_addr = 22'h000004;
      i_req = 1'b1;
      c0 = cyc;
      c1 = -1;
      t = 0;
      while (c1 < 0 && t < 500) begin
         @(negedge clk);
         t++;
         if (ps_read_en) c1 = cyc;
      end
      chk("busy_first_issue", c1 - c0, 6);
      wait_ack(1'b0, at);
      i_req = 1'b0;
      chk("busy_rdata", i_rdata, ref_word(22'h000004));
      chk("busy_nrd", n_rd - b_rd, 2);

      // random mix
      for (int k = 0; k < 40; k++) begin
         lat = $urandom_range(8, 1);
         a = rnd_addr();
         w = $urandom;
         s = 4'($urandom);
         we = 1'($urandom);
         if ($urandom_range(1) == 0) begin
            i_read(a, "rnd_i_rdata");
         end else begin
            b_wr = n_wr;
            d_op(we, a, w, s, "rnd_d_rdata");
            if (we)
               chk("rnd_wr_count", n_wr - b_wr,
                   int'(|s[1:0]) + int'(|s[3:2]));
         end
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
